mem_stage: RTL

Memory stage of the 16-bit pipelined datapath. It sits directly downstream of the execute stage and consumes that stage's registered control bits, ALU result, store data and destination address. It performs data-memory loads and stores to an internal synchronous RAM, and bus reads to the neural-network fabric over a req/ack handshake, stalling the pipeline while a bus read is outstanding. It also feeds the forwarding path back to execute and registers results into the MEM/WB pipeline register.

---
 rtl/mem_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : pipeline memory stage with data RAM, fabric bus read and MEM/WB
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_regwrite_in,
  input  logic        mem_memtoreg_in,
  input  logic        mem_bustoreg_in,
  input  logic        mem_memread_in,
  input  logic        mem_memwrite_in,
  input  logic [15:0] mem_alu_in,
  input  logic [15:0] mem_wrdata_in,
  input  logic [3:0]  mem_regwraddr_in,
  output logic        fwd_regwrite,
  output logic        fwd_memread,
  output logic [3:0]  fwd_regwraddr,
  output logic [15:0] fwd_regwrdata,
  output logic        stall,
  output logic        bus_req,
  output logic [15:0] bus_addr,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic        wb_regwrite,
  output logic [3:0]  wb_regwraddr,
  output logic [15:0] wb_regwrdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          bus_req_q;
  logic [15:0]   bus_addr_q;
  logic          bus_err_q;
  logic          wb_regwrite_q;
  logic          wb_memtoreg_q;
  logic [3:0]    wb_regwraddr_q;
  logic [15:0]   wb_result_q;
  logic [15:0]   ram_q;
  logic [15:0]   mem_q [DEPTH];

  logic          bus_done;
  logic          mem_access;
  logic [AW-1:0] ram_addr;

  assign fwd_regwrite  = mem_regwrite_in;
  assign fwd_memread   = mem_memread_in | mem_bustoreg_in;
  assign fwd_regwraddr = mem_regwraddr_in;
  assign fwd_regwrdata = mem_alu_in;

  // Ack takes priority over the timeout when both land in the same cycle.
  assign bus_done   = bus_ack | (cnt_q == CNT_MAX);
  assign stall      = (state_q == S_IDLE) ? mem_bustoreg_in : ~bus_done;
  assign mem_access = (state_q == S_IDLE) & ~mem_bustoreg_in;
  assign ram_addr   = mem_alu_in[AW-1:0];

  // Data RAM is not reset; a same-edge read of a written word returns old data.
  always_ff @(posedge clk) begin
    if (mem_access && mem_memwrite_in) begin
      mem_q[ram_addr] <= mem_wrdata_in;
    end
    if (mem_access && (mem_memread_in || mem_memtoreg_in)) begin
      ram_q <= mem_q[ram_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bus_req_q      <= 1'b0;
      bus_addr_q     <= '0;
      bus_err_q      <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwraddr_q <= '0;
      wb_result_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_bustoreg_in) begin
            state_q       <= S_WAIT;
            bus_req_q     <= 1'b1;
            bus_addr_q    <= mem_alu_in;
            cnt_q         <= '0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
          end else begin
            wb_regwrite_q  <= mem_regwrite_in;
            wb_regwraddr_q <= mem_regwraddr_in;
            wb_memtoreg_q  <= mem_memtoreg_in;
            wb_result_q    <= mem_alu_in;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus_done) begin
            state_q        <= S_IDLE;
            bus_req_q      <= 1'b0;
            wb_regwrite_q  <= mem_regwrite_in;
            wb_regwraddr_q <= mem_regwraddr_in;
            wb_memtoreg_q  <= 1'b0;
            wb_result_q    <= bus_ack ? bus_rdata : 16'hFFFF;
            if (!bus_ack) begin
              bus_err_q <= 1'b1;
            end
          end else begin
            wb_regwrite_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_addr     = bus_addr_q;
  assign bus_err      = bus_err_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_regwraddr = wb_regwraddr_q;
  assign wb_regwrdata = wb_memtoreg_q ? ram_q : wb_result_q;

endmodule

`default_nettype wire
